// File: rtl/ap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ap_pkg : shared types and sizes for the AP window checker            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ap_pkg;

  localparam int AP_N  = 7;
  localparam int AP_DW = 8;

  typedef logic [AP_DW-1:0] ap_elem_t;
  typedef ap_elem_t ap_win_t [AP_N];

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    RESULT = 1'b1
  } ap_state_e;

endpackage
`default_nettype wire

// File: rtl/ap_stream_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ap_stream_ctrl_if : sample-in and verdict-out handshake bundle       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ap_stream_ctrl_if;

  logic             s_valid;
  logic             s_ready;
  ap_pkg::ap_elem_t s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic             m_is_ap;
  ap_pkg::ap_elem_t m_diff;

  // master: sample producer and verdict consumer
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_is_ap, m_diff
  );

  // slave: the stream controller
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_is_ap, m_diff
  );

endinterface
`default_nettype wire

// File: rtl/AP_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | AP_detector : combinational mod-256 arithmetic-progression check    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module AP_detector
  import ap_pkg::*;
(
  input  ap_elem_t A,
  input  ap_elem_t B,
  input  ap_elem_t C,
  input  ap_elem_t D,
  input  ap_elem_t E,
  input  ap_elem_t F,
  input  ap_elem_t G,
  output logic     is_AP
);

  ap_elem_t step;

  always_comb begin
    step  = B - A;
    // 8-bit operands keep every term wrapped mod 256
    is_AP = (C == ap_elem_t'(A + 8'd2 * step)) &&
            (D == ap_elem_t'(A + 8'd3 * step)) &&
            (E == ap_elem_t'(A + 8'd4 * step)) &&
            (F == ap_elem_t'(A + 8'd5 * step)) &&
            (G == ap_elem_t'(A + 8'd6 * step));
  end

endmodule
`default_nettype wire

// File: rtl/ap_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ap_stream_ctrl : assembles 7-sample windows, returns AP verdicts     |
// | Optional: AP_SLIDING_EN selects a sliding instead of tiled window    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ap_stream_ctrl
  import ap_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire              clk,
  input  wire              rst,
  ap_stream_ctrl_if.slave  bus,
  input  wire              cnt_clr,
  output logic [CNT_W-1:0] ap_count
);

`ifdef AP_SLIDING_EN
  localparam bit SLIDING_EN = 1'b1;
`else
  localparam bit SLIDING_EN = 1'b0;
`endif

  localparam logic [2:0] FILL_LAST = 3'(AP_N - 1);
  localparam logic [2:0] FILL_FULL = 3'(AP_N);

  ap_state_e        state_q, state_d;
  ap_win_t          win_q, win_d, cand;
  logic [2:0]       fill_q, fill_d;
  logic             is_ap_q, is_ap_d;
  ap_elem_t         diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic m_valid_w, s_ready_w;
  logic s_hs, m_hs, shift, win_done, det_ap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (win_done) state_d = RESULT;
      RESULT:  if (win_done)  state_d = RESULT;
               else if (m_hs) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    m_valid_w = (state_q == RESULT);
    s_ready_w = !m_valid_w || bus.m_ready;
  end

  assign s_hs     = bus.s_valid && s_ready_w;
  assign m_hs     = m_valid_w && bus.m_ready;
  assign shift    = SLIDING_EN && (fill_q == FILL_FULL);
  assign win_done = s_hs && ((fill_q == FILL_LAST) || shift);

  // Candidate window: the in-flight sample always lands in position G
  always_comb begin
    for (int k = 0; k < AP_N - 1; k++) begin
      cand[k] = shift ? win_q[k+1] : win_q[k];
    end
    cand[AP_N-1] = bus.s_data;
  end

  AP_detector u_det (
    .A     (cand[0]),
    .B     (cand[1]),
    .C     (cand[2]),
    .D     (cand[3]),
    .E     (cand[4]),
    .F     (cand[5]),
    .G     (cand[6]),
    .is_AP (det_ap)
  );

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    is_ap_d = is_ap_q;
    diff_d  = diff_q;
    if (s_hs) begin
      if (shift) win_d = cand;
      else       win_d[fill_q] = bus.s_data;
      if (win_done) begin
        fill_d  = SLIDING_EN ? FILL_FULL : 3'd0;
        is_ap_d = det_ap;
        diff_d  = cand[1] - cand[0];
      end else begin
        fill_d  = fill_q + 3'd1;
      end
      // frame end drops any partial window and restarts the fill
      if (bus.s_last) fill_d = 3'd0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                          cnt_d = '0;
    else if (m_hs && is_ap_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < AP_N; k++) win_q[k] <= '0;
      fill_q  <= 3'd0;
      is_ap_q <= 1'b0;
      diff_q  <= '0;
      cnt_q   <= '0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      is_ap_q <= is_ap_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.s_ready = s_ready_w;
  assign bus.m_valid = m_valid_w;
  assign bus.m_is_ap = is_ap_q;
  assign bus.m_diff  = diff_q;
  assign ap_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ap_stream_ctrl : directed + random bench with a queue-based model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ap_stream_ctrl;

  localparam int TB_CNT_W = 2;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;
`ifdef AP_SLIDING_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                cnt_clr;
  logic [TB_CNT_W-1:0] ap_count;

  ap_stream_ctrl_if bus ();

  ap_stream_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cnt_clr  (cnt_clr),
    .ap_count (ap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_res    = 0;

  // model: what the spec says the outputs must be
  logic [7:0] cur[$];
  bit         e_pend;
  bit         e_ap;
  logic [7:0] e_diff;
  int         e_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    cur.delete();
    e_pend = 1'b0;
    e_ap   = 1'b0;
    e_diff = 8'd0;
    e_cnt  = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic l,
                            input logic mr, input logic clr);
    bit acc, mhs, newres, ok;
    logic [7:0] a, df;
    acc    = v && (!e_pend || mr);
    mhs    = e_pend && mr;
    newres = 1'b0;
    if (clr) e_cnt = 0;
    else if (mhs && e_ap && e_cnt < CMAX) e_cnt++;
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == 7) begin
        a  = cur[0];
        df = cur[1] - cur[0];
        ok = 1'b1;
        for (int k = 0; k < 7; k++) if (cur[k] != 8'(a + k * df)) ok = 1'b0;
        e_ap   = ok;
        e_diff = df;
        newres = 1'b1;
        if (SLIDE) void'(cur.pop_front());
        else       cur.delete();
      end
      if (l) cur.delete();
    end
    if (newres)   e_pend = 1'b1;
    else if (mhs) e_pend = 1'b0;
  endtask

  // one clock: apply inputs, check ready, advance model, check registered outputs
  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic mr, input logic clr);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.m_ready = mr;
    cnt_clr     = clr;
    #1;
    check("s_ready", bus.s_ready, !e_pend || mr);
    if (e_pend && mr) n_res++;
    model_step(v, d, l, mr, clr);
    @(posedge clk);
    #1;
    check("m_valid",  bus.m_valid, e_pend);
    check("m_is_ap",  bus.m_is_ap, e_ap);
    check("m_diff",   bus.m_diff,  e_diff);
    check("ap_count", ap_count,    e_cnt);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send7(input logic [7:0] a, input logic [7:0] st, input logic mr);
    for (int k = 0; k < 7; k++) drive(1'b1, 8'(a + k * st), 1'b0, mr, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_res;
    logic [7:0] geo[7];
    logic [7:0] gb, gs, gd;
    int gk;
    bit rdy;
    logic v, l, mr, clr;

    do_reset();
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_is_ap", bus.m_is_ap, 0);
    check("rst_m_diff",  bus.m_diff,  0);
    check("rst_count",   ap_count,    0);
    check("rst_s_ready", bus.s_ready, 1);

    // 1..7
    send7(8'd1, 8'd1, 1'b1);
    check("lit_inc_valid", bus.m_valid, 1);
    check("lit_inc_ap",    bus.m_is_ap, 1);
    check("lit_inc_diff",  bus.m_diff,  1);
    idle(1);
    check("lit_inc_count", ap_count, 1);

    // wrap-around AP, then a geometric non-AP
    send7(8'd250, 8'd2, 1'b1);
    check("lit_wrap_ap",   bus.m_is_ap, 1);
    check("lit_wrap_diff", bus.m_diff,  2);
    idle(1);
    geo = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    for (int k = 0; k < 7; k++) drive(1'b1, geo[k], 1'b0, 1'b1, 1'b0);
    check("lit_geo_ap",   bus.m_is_ap, 0);
    check("lit_geo_diff", bus.m_diff,  2);
    idle(1);
    check("lit_geo_count", ap_count, 2);

    // back-pressure: result pending, 8th sample stalls
    send7(8'd10, 8'd10, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd80;
    bus.m_ready = 1'b0;
    #1;
    check("lit_stall_ready", bus.s_ready, 0);
    drive(1'b1, 8'd80, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'd80, 1'b0, 1'b0, 1'b0);
    check("lit_hold_ap",   bus.m_is_ap, 1);
    check("lit_hold_diff", bus.m_diff,  10);
    drive(1'b1, 8'd80, 1'b0, 1'b1, 1'b0);
    check("lit_release_valid", bus.m_valid, 0);
    for (int k = 1; k < 7; k++) drive(1'b1, 8'(80 + 10 * k), 1'b0, 1'b1, 1'b0);
    check("lit_second_ap", bus.m_is_ap, 1);
    idle(1);
    check("lit_sat3", ap_count, 3);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("lit_clr0", ap_count, 0);

    // s_last on the 4th sample drops the partial window
    base_res = n_res;
    drive(1'b1, 8'd5,  1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'd15, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'd20, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("lit_last_nores", bus.m_valid, 0);
    send7(8'd9, 8'd0, 1'b1);
    check("lit_const_ap",   bus.m_is_ap, 1);
    check("lit_const_diff", bus.m_diff,  0);
    idle(1);
    check("lit_last_nres", n_res - base_res, 1);

    // reset mid-window
    for (int k = 0; k < 5; k++) drive(1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
    do_reset();
    base_res = n_res;
    send7(8'd3, 8'd3, 1'b1);
    idle(3);
    check("lit_rst_one_result", n_res - base_res, 1);

    // saturation with 5 positive windows, then clear
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    for (int w = 0; w < 5; w++) begin
      send7(8'd1, 8'd1, 1'b1);
      idle(1);
    end
    check("lit_sat_count", ap_count, 3);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("lit_sat_clr", ap_count, 0);

    // 1..8: sliding gives two verdicts, tiled gives one
    do_reset();
    base_res = n_res;
    for (int k = 1; k <= 8; k++) drive(1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
    idle(2);
    check("lit_1to8_results", n_res - base_res, SLIDE ? 2 : 1);

    // randomized traffic, biased toward progressions
    do_reset();
    gb = 8'($urandom);
    gs = 8'd1;
    gk = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      v   = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 63) == 0);
      gd  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(gb + gk * gs);
      rdy = !e_pend || mr;
      if (v && rdy) begin
        gk++;
        if (gk == 7 || $urandom_range(0, 15) == 0) begin
          gk = 0;
          gb = 8'($urandom);
          case ($urandom_range(0, 4))
            0:       gs = 8'd0;
            1:       gs = 8'd255;
            2:       gs = 8'd1;
            3:       gs = 8'd37;
            default: gs = 8'($urandom);
          endcase
        end
      end
      drive(v, gd, l, mr, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ap_stream_ctrl.md
# ap_stream_ctrl

Streaming front-end for the `AP_detector` combinational checker. It accepts 8-bit samples one per handshake and assembles them into 7-element windows. It presents each complete window to the detector and returns a registered is-arithmetic-progression verdict on a valid/ready result port. It sits between a byte-stream producer and any consumer of per-window AP verdicts, and keeps a saturating count of positive windows.

## Interface
- `CNT_W`, 16, width of the positive-window counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  input sample accepted when `s_valid && s_ready`
- `s_data`  in  8  sample; first sample of a window is element A, seventh is element G
- `s_last`  in  1  frame end, qualified by the input handshake
- `m_valid`  out  1  result valid
- `m_ready`  in  1  result consumed when `m_valid && m_ready`
- `m_is_ap`  out  1  window is an arithmetic progression
- `m_diff`  out  8  B − A mod 256 for the reported window
- `ap_count`  out  CNT_W  count of consumed results with `m_is_ap = 1`
- `cnt_clr`  in  1  synchronous clear of `ap_count`

## Operation
- Window: 7×8-bit registers plus a 3-bit fill count `fill` (0..7).
  - Each accepted sample is written at position `fill`.
  - `fill` increments on each accepted sample.
- States:
  - FILL: `fill < 7`, no result pending.
  - RESULT: `m_valid = 1`.
- FILL → RESULT: on the cycle the 7th sample is accepted.
  - The 7 window values (with the new sample in position G) drive `AP_detector`.
  - Its output registers into `m_is_ap`.
  - B − A registers into `m_diff`.
- RESULT → FILL: on result handshake, when no new window completes in that same cycle.
- `s_ready = !m_valid || m_ready`: one result slot, and full throughput when `m_ready` stays high.
- Arithmetic is mod 256. The window is an AP iff, for k = 1..6, element k equals A + k·(B − A) mod 256.
  - A constant window is an AP.
  - Descending and wrap-around sequences are valid APs.
- `s_last` on an accepted sample ends the frame.
  - If this sample completes the window, the result is produced as normal.
  - Otherwise the partial window is discarded and no result is produced.
  - In both cases `fill` returns to 0.
- `ap_count` increments on a result handshake with `m_is_ap = 1` and saturates at all-ones.
  - `cnt_clr` takes priority over the increment. The count is 0 in the cycle after `cnt_clr`.

## Timing
- Reset values:
  - `m_valid = 0`, `m_is_ap = 0`, `m_diff = 0`, `ap_count = 0`, `fill = 0`.
  - `s_ready = 1` from the cycle after reset.
- Latency: `m_valid` rises in the cycle after the 7th sample handshake.
- Result outputs stay stable while `m_valid && !m_ready`.
- Simultaneous result handshake and 7th-sample handshake: `m_valid` stays 1 and the outputs update to the new window on the next edge.
- Reset mid-window or with a result pending: the partial window and the pending result are dropped with no output.
- `s_data` is sampled only on a handshake. Cycles with `s_valid = 0` do not advance `fill`.

## Configuration
- `AP_SLIDING_EN` defined: sliding window.
  - After the first full window, `fill` stays at 7.
  - Each further accepted sample shifts the window by one (old A discarded, new sample becomes G) and produces a result one cycle later.
  - `s_last` still resets `fill` to 0 after its result.
- `AP_SLIDING_EN` undefined: non-overlapping windows. `fill` returns to 0 after every 7th sample.

## Structure
- Shared package `ap_pkg`:
  - `AP_N = 7`, `AP_DW = 8`.
  - `typedef logic [AP_DW-1:0] ap_elem_t`.
  - `typedef ap_elem_t ap_win_t [AP_N]`.
  - State enum `ap_state_e {FILL, RESULT}`.
- Single sub-module: the existing combinational `AP_detector`, instantiated once. Its inputs are fed from the window registers, with the in-flight sample substituted at position G.

## Test plan
- Samples 1..7, `m_ready = 1` → one result: `m_is_ap = 1`, `m_diff = 1`, `ap_count = 1`.
- Samples 250,252,254,0,2,4,6 → `m_is_ap = 1`, `m_diff = 2`. Samples 2,4,8,16,32,64,128 → `m_is_ap = 0`, `m_diff = 2`, and `ap_count` does not increment.
- `m_ready = 0` after a full window:
  - `s_ready` is 0 and the 8th sample stalls.
  - `m_is_ap` and `m_diff` hold.
  - Raising `m_ready` accepts the stalled sample in the same cycle.
- `s_last` on the 4th of 5,10,15,20 → no result. Next samples 7×9 → `m_is_ap = 1`, `m_diff = 0`.
- `rst` pulsed after 5 samples → no result; 7 fresh samples then produce exactly one result. `cnt_clr` with `CNT_W = 2` after 5 positive windows → count saturates at 3, then reads 0.
- With `AP_SLIDING_EN`, samples 1..8 → two results (1..7 and 2..8), both `m_is_ap = 1`. Without it, the same stream → one result.
